regfile_port_sequencer: RTL
===========================

Name: regfile_port_sequencer

Overview:
- Single-clock controller that owns the control, address and data pins of the 32 x 16-bit data register file.
- Shares the file between NREQ requesters using round-robin arbitration and a valid/ready handshake.
- Performs the post-reset clear sweep: all registers set to 0, then the stack pointer register set to SP_INIT.
- Sits between the control unit/debug port and the register file, replacing direct strobe driving by individual units.

Parameters:
- NREQ, 2, number of requesters (2..4 supported).
- DATA_W, 16, register data width.
- ADDR_W, 5, register index width.
- NREGS, 32, number of registers swept at init.
- SP_INDEX, 29, stack pointer register index.
- SP_INIT, 69, stack pointer value after init.

Ports:
- clk  in  1  clock; all state on rising edge.
- reset  in  1  reset, synchronous, active-high.
- req_valid  in  NREQ  per-requester operation request.
- req_ready  out  NREQ  per-requester accept; one-hot or zero.
- req_we  in  NREQ  per-requester write enable for the operation.
- req_raddr1  in  NREQ*ADDR_W  read index 1, packed, requester i at slice i.
- req_raddr2  in  NREQ*ADDR_W  read index 2, packed.
- req_waddr  in  NREQ*ADDR_W  write index, packed.
- req_wdata  in  NREQ*DATA_W  write data, packed.
- rsp_valid  out  NREQ  one-cycle response strobe to the owning requester.
- rsp_data1  out  DATA_W  read data 1; shared, qualified by rsp_valid.
- rsp_data2  out  DATA_W  read data 2; shared, qualified by rsp_valid.
- rf_read_en  out  1  register file read strobe.
- rf_write_en  out  1  register file write strobe.
- rf_raddr1  out  16  zero-extended read index 1.
- rf_raddr2  out  16  zero-extended read index 2.
- rf_waddr  out  16  zero-extended write index.
- rf_wdata  out  16  write data.
- rf_rdata1  in  16  register file read data 1; valid the cycle after rf_read_en.
- rf_rdata2  in  16  register file read data 2; valid the cycle after rf_read_en.
- init_done  out  1  high once the sweep completes; stays high until the next reset.

Behaviour:
- FSM states: INIT, IDLE, ISSUE, RESP. All rf_* outputs are registered.
- Reset (any state, mid-operation included):
  - Next state INIT, init_ptr=0, init_done=0.
  - req_ready, rsp_valid, rf_read_en, rf_write_en = 0.
  - Any in-flight operation is dropped with no response.
  - Last-grant pointer is set to NREQ-1, so requester 0 wins first.
- INIT:
  - Each cycle: rf_write_en=1, rf_waddr=init_ptr.
  - rf_wdata = SP_INIT when init_ptr==SP_INDEX, else 0.
  - init_ptr increments each cycle. After the write at NREGS-1, go to IDLE.
  - Sweep takes exactly NREGS=32 cycles; init_done rises in the first IDLE cycle.
  - req_ready=0 throughout INIT.
- IDLE:
  - Combinational round-robin grant: search starts at last_grant+1 mod NREQ; first valid requester wins.
  - req_ready[g]=1 only in IDLE and only for g.
  - Accept = valid & ready. On accept: latch g, we, raddr1, raddr2, waddr, wdata; update last_grant=g; go to ISSUE.
  - A request withdrawn before accept has no effect.
- ISSUE (1 cycle): rf_read_en=1, rf_write_en=latched we, addresses/data from latches.
  - Same-index read and write in one operation returns the OLD value (read-before-write).
- RESP (1 cycle): rsp_valid[g]=1, rsp_data1/2 = rf_rdata1/2, then IDLE.
- Latency and throughput:
  - Accept at cycle T -> rf strobes in T+1 -> rsp_valid in T+2 -> next accept earliest T+3.
  - Sustained: one operation per 3 cycles.
- rsp_data1/2 hold the last response value outside RESP.
- Writes to any index, SP_INDEX included, are allowed after init.

Decomposition:
- Shared package (regfile_pkg): DATA_W, ADDR_W, NREGS, SP_INDEX, SP_INIT, FSM state enum.
- One sub-module: rr_arbiter (NREQ, req vector + last_grant -> one-hot grant); combinational, reusable by the memory port.

Test Plan:
- Reset, then idle for 32 cycles -> rf_write_en high for exactly 32 cycles, waddr 0..31, wdata 0 except 69 at index 29; init_done high in cycle 33.
- Requests during INIT -> req_ready stays 0; first accept occurs in the first IDLE cycle.
- Req0 writes 0x1234 to r5, then reads r5/r29 -> rsp_data1=0x1234, rsp_data2=69, rsp_valid[0] 2 cycles after accept.
- Both requesters valid continuously -> grants alternate 0,1,0,1; accepts spaced exactly 3 cycles apart.
- Single op: write 0xBEEF to r7 and read r7 -> response 0x0000; a following read returns 0xBEEF.
- Reset asserted in ISSUE -> no rsp_valid; sweep restarts at index 0; r29 returns 69 afterwards.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the data register file and its port sequencer.
package regfile_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 5;
  localparam int NREGS    = 32;
  localparam int SP_INDEX = 29;
  localparam int SP_INIT  = 69;
  localparam int RF_W     = 16;   // width of the register file address/data pins

  // Sequencer FSM encoding
  localparam logic [1:0] ST_INIT  = 2'd0;
  localparam logic [1:0] ST_IDLE  = 2'd1;
  localparam logic [1:0] ST_ISSUE = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  // Register indices travel on 16-bit pins; upper bits are always zero.
  function automatic logic [RF_W-1:0] zext_addr(input logic [ADDR_W-1:0] a);
    return {{(RF_W-ADDR_W){1'b0}}, a};
  endfunction

endpackage

// File: rtl/regfile_port_sequencer_if.sv
// Requester handshake plus register file pin bundle for the port sequencer.
interface regfile_port_sequencer_if #(parameter int NREQ = 2);
  import regfile_pkg::*;

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*ADDR_W-1:0] req_raddr1;
  logic [NREQ*ADDR_W-1:0] req_raddr2;
  logic [NREQ*ADDR_W-1:0] req_waddr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_data1;
  logic [DATA_W-1:0]      rsp_data2;

  logic                   rf_read_en;
  logic                   rf_write_en;
  logic [RF_W-1:0]        rf_raddr1;
  logic [RF_W-1:0]        rf_raddr2;
  logic [RF_W-1:0]        rf_waddr;
  logic [RF_W-1:0]        rf_wdata;
  logic [RF_W-1:0]        rf_rdata1;
  logic [RF_W-1:0]        rf_rdata2;

  // Sequencer side
  modport slave (
    input  req_valid, req_we, req_raddr1, req_raddr2, req_waddr, req_wdata,
    input  rf_rdata1, rf_rdata2,
    output req_ready, rsp_valid, rsp_data1, rsp_data2,
    output rf_read_en, rf_write_en, rf_raddr1, rf_raddr2, rf_waddr, rf_wdata
  );

  // Requesters plus register file side
  modport master (
    output req_valid, req_we, req_raddr1, req_raddr2, req_waddr, req_wdata,
    output rf_rdata1, rf_rdata2,
    input  req_ready, rsp_valid, rsp_data1, rsp_data2,
    input  rf_read_en, rf_write_en, rf_raddr1, rf_raddr2, rf_waddr, rf_wdata
  );

endinterface

// File: rtl/regfile_port_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: search starts one past the last grant.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int LG_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [LG_W-1:0] last_grant,
  output logic [NREQ-1:0] grant
);

  // Walk offsets 1..NREQ from last_grant; first valid requester wins.
  always_comb begin
    logic found;
    grant = '0;
    found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!found && req[i] && (i == ((int'(last_grant) + k) % NREQ))) begin
          grant[i] = 1'b1;
          found    = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/regfile_port_sequencer.sv
// Register file port sequencer: post-reset clear sweep, then round-robin
// shared access, one operation per three cycles (accept, issue, respond).
module regfile_port_sequencer
  import regfile_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  regfile_port_sequencer_if.slave  bus,
  output logic                     init_done
);

  localparam int LG_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [1:0]        state;
  logic [ADDR_W-1:0] init_ptr;
  logic [LG_W-1:0]   last_grant;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   owner_q;
  logic              accept;

  logic              rf_read_en_q;
  logic              rf_write_en_q;
  logic [RF_W-1:0]   rf_raddr1_q;
  logic [RF_W-1:0]   rf_raddr2_q;
  logic [RF_W-1:0]   rf_waddr_q;
  logic [RF_W-1:0]   rf_wdata_q;
  logic [DATA_W-1:0] rsp_data1_q;
  logic [DATA_W-1:0] rsp_data2_q;

  logic              sel_we;
  logic [ADDR_W-1:0] sel_raddr1;
  logic [ADDR_W-1:0] sel_raddr2;
  logic [ADDR_W-1:0] sel_waddr;
  logic [DATA_W-1:0] sel_wdata;
  logic [LG_W-1:0]   sel_idx;

  rr_arbiter #(.NREQ(NREQ), .LG_W(LG_W)) u_arb (
    .req        (bus.req_valid),
    .last_grant (last_grant),
    .grant      (grant)
  );

  assign accept        = (state == ST_IDLE) && (|grant);
  assign bus.req_ready = (state == ST_IDLE) ? grant : '0;

  // Pull the granted requester's operation fields out of the packed buses.
  always_comb begin
    sel_we     = 1'b0;
    sel_raddr1 = '0;
    sel_raddr2 = '0;
    sel_waddr  = '0;
    sel_wdata  = '0;
    sel_idx    = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_we     = bus.req_we[i];
        sel_raddr1 = bus.req_raddr1[i*ADDR_W +: ADDR_W];
        sel_raddr2 = bus.req_raddr2[i*ADDR_W +: ADDR_W];
        sel_waddr  = bus.req_waddr[i*ADDR_W +: ADDR_W];
        sel_wdata  = bus.req_wdata[i*DATA_W +: DATA_W];
        sel_idx    = LG_W'(i);
      end
    end
  end

  // FSM and registered register-file pins; pin registers are loaded on the
  // edge entering the cycle in which they must be visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_INIT;
      init_ptr      <= '0;
      init_done     <= 1'b0;
      last_grant    <= LG_W'(NREQ - 1);
      owner_q       <= '0;
      rf_read_en_q  <= 1'b0;
      rf_write_en_q <= 1'b0;
      rf_raddr1_q   <= '0;
      rf_raddr2_q   <= '0;
      rf_waddr_q    <= '0;
      rf_wdata_q    <= '0;
      rsp_data1_q   <= '0;
      rsp_data2_q   <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          rf_read_en_q  <= 1'b0;
          rf_write_en_q <= 1'b1;
          rf_waddr_q    <= zext_addr(init_ptr);
          rf_wdata_q    <= (init_ptr == ADDR_W'(SP_INDEX)) ? RF_W'(SP_INIT) : '0;
          init_ptr      <= init_ptr + ADDR_W'(1);
          if (init_ptr == ADDR_W'(NREGS - 1)) begin
            state     <= ST_IDLE;
            init_done <= 1'b1;
          end
        end
        ST_IDLE: begin
          rf_read_en_q  <= 1'b0;
          rf_write_en_q <= 1'b0;
          if (accept) begin
            rf_read_en_q  <= 1'b1;
            rf_write_en_q <= sel_we;
            rf_raddr1_q   <= zext_addr(sel_raddr1);
            rf_raddr2_q   <= zext_addr(sel_raddr2);
            rf_waddr_q    <= zext_addr(sel_waddr);
            rf_wdata_q    <= RF_W'(sel_wdata);
            owner_q       <= grant;
            last_grant    <= sel_idx;
            state         <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          rf_read_en_q  <= 1'b0;
          rf_write_en_q <= 1'b0;
          state         <= ST_RESP;
        end
        default: begin
          rsp_data1_q <= DATA_W'(bus.rf_rdata1);
          rsp_data2_q <= DATA_W'(bus.rf_rdata2);
          state       <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.rf_read_en  = rf_read_en_q;
  assign bus.rf_write_en = rf_write_en_q;
  assign bus.rf_raddr1   = rf_raddr1_q;
  assign bus.rf_raddr2   = rf_raddr2_q;
  assign bus.rf_waddr    = rf_waddr_q;
  assign bus.rf_wdata    = rf_wdata_q;

  // Read data passes straight through in RESP and is held afterwards.
  assign bus.rsp_valid = (state == ST_RESP) ? owner_q : '0;
  assign bus.rsp_data1 = (state == ST_RESP) ? DATA_W'(bus.rf_rdata1) : rsp_data1_q;
  assign bus.rsp_data2 = (state == ST_RESP) ? DATA_W'(bus.rf_rdata2) : rsp_data2_q;

endmodule
